// File: rtl/m_layer_input_gen_if.sv
// Frame-in / window-out bundle for the layer-input buffer.
// master = producer/consumer side, slave = buffer side.
interface m_layer_input_gen_if #(
  parameter int DW = 16
);
  logic signed [DW-1:0] map_in;
  logic                 wr;
  logic                 stall;
  logic signed [DW-1:0] map_out;
  logic                 k_ready;
  logic                 k_last;
  logic                 k_loop;
  logic                 ready;
  logic                 err_ovf;

  modport master (
    output map_in, wr, stall,
    input  map_out, k_ready, k_last, k_loop, ready, err_ovf
  );

  modport slave (
    input  map_in, wr, stall,
    output map_out, k_ready, k_last, k_loop, ready, err_ovf
  );
endinterface

// File: rtl/m_layer_input_gen.sv
// Layer-input buffer: stores one CH x MAP_W x MAP_W frame, then replays every
// KxK window (stride STRIDE) NUM_LOOP times through a 2-stage read pipeline.
module m_layer_input_gen #(
  parameter int DW       = 16,
  parameter int MAP_W    = 22,
  parameter int CH       = 1,
  parameter int K        = 5,
  parameter int STRIDE   = 1,
  parameter int NUM_LOOP = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  m_layer_input_gen_if.slave bus
);

  localparam int FRAME = MAP_W * MAP_W * CH;
  localparam int OUT_W = (MAP_W - K) / STRIDE + 1;
  localparam int AW    = $clog2(FRAME);
  localparam int AWS   = (AW < 1) ? 1 : AW;
  localparam int PW    = $clog2(NUM_LOOP + 1);

  localparam logic [AWS-1:0] C_ONE     = AWS'(1);
  localparam logic [AWS-1:0] C_KM1     = AWS'(K - 1);
  localparam logic [AWS-1:0] C_OWM1    = AWS'(OUT_W - 1);
  localparam logic [AWS-1:0] C_CHM1    = AWS'(CH - 1);
  localparam logic [AWS-1:0] C_MW      = AWS'(MAP_W);
  localparam logic [AWS-1:0] C_STR     = AWS'(STRIDE);
  localparam logic [AWS-1:0] C_ROWSTEP = AWS'(STRIDE * MAP_W);
  localparam logic [AWS-1:0] C_PLANE   = AWS'(MAP_W * MAP_W);
  localparam logic [AWS-1:0] C_LAST_WR = AWS'(FRAME - 1);
  localparam logic [PW-1:0]  C_PASSM1  = PW'(NUM_LOOP - 1);

  generate
    if (K > MAP_W) begin : g_err_k
      $error("m_layer_input_gen: K must not exceed MAP_W");
    end
    if (((MAP_W - K) % STRIDE) != 0) begin : g_err_stride
      $error("m_layer_input_gen: (MAP_W-K) must be a multiple of STRIDE");
    end
    if (NUM_LOOP == 0) begin : g_err_loop
      $error("m_layer_input_gen: NUM_LOOP must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_DONE} state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_err_ovf;
  logic [AWS-1:0]        r_addr_wr;
  logic signed [DW-1:0]  r_mem [0:FRAME-1];

  // Stage 0: window counters plus running address bases
  logic                  r_issue;
  logic [PW-1:0]         r_pass;
  logic [AWS-1:0]        r_oy, r_ox, r_ch, r_ky, r_kx;
  logic [AWS-1:0]        r_oy_base, r_ox_base, r_ch_base, r_ky_base;

  // Stage 1: address register, stage 2: RAM output register
  logic                  r_v1, r_last1, r_loop1, r_fin1;
  logic [AWS-1:0]        r_rd_addr;
  logic                  r_k_ready, r_k_last, r_k_loop, r_fin2;
  logic signed [DW-1:0]  r_map_out;

  logic                  w_adv, w_mem_we;
  logic                  w_kx_end, w_ky_end, w_ch_end, w_ox_end, w_oy_end, w_pass_end;
  logic                  w_win_end, w_pass_done, w_final;
  logic [AWS-1:0]        w_addr;

  // The whole read pipeline holds only while a valid beat is being refused.
  assign w_adv       = ~(r_k_ready & bus.stall);
  assign w_mem_we    = bus.wr & (r_state != ST_STREAM);

  assign w_kx_end    = (r_kx == C_KM1);
  assign w_ky_end    = (r_ky == C_KM1);
  assign w_ch_end    = (r_ch == C_CHM1);
  assign w_ox_end    = (r_ox == C_OWM1);
  assign w_oy_end    = (r_oy == C_OWM1);
  assign w_pass_end  = (r_pass == C_PASSM1);
  assign w_win_end   = w_kx_end & w_ky_end & w_ch_end;
  assign w_pass_done = w_win_end & w_ox_end & w_oy_end;
  assign w_final     = w_pass_done & w_pass_end;

  assign w_addr = r_ch_base + r_oy_base + r_ky_base + r_ox_base + r_kx;

  always_ff @(posedge clk_in) begin
    if (w_mem_we) begin
      r_mem[r_addr_wr] <= bus.map_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_ready   <= 1'b1;
      r_err_ovf <= 1'b0;
      r_addr_wr <= '0;
      r_issue   <= 1'b0;
      r_pass    <= '0;
      r_oy      <= '0;
      r_ox      <= '0;
      r_ch      <= '0;
      r_ky      <= '0;
      r_kx      <= '0;
      r_oy_base <= '0;
      r_ox_base <= '0;
      r_ch_base <= '0;
      r_ky_base <= '0;
      r_v1      <= 1'b0;
      r_last1   <= 1'b0;
      r_loop1   <= 1'b0;
      r_fin1    <= 1'b0;
      r_rd_addr <= '0;
      r_k_ready <= 1'b0;
      r_k_last  <= 1'b0;
      r_k_loop  <= 1'b0;
      r_fin2    <= 1'b0;
      r_map_out <= '0;
    end else begin
      case (r_state)
        // DONE shares the write path: its address counter is already 0.
        ST_FILL, ST_DONE: begin
          if (bus.wr) begin
            if (r_addr_wr == C_LAST_WR) begin
              r_state   <= ST_STREAM;
              r_addr_wr <= '0;
              r_ready   <= 1'b0;
              r_issue   <= 1'b1;
            end else begin
              r_state   <= ST_FILL;
              r_addr_wr <= r_addr_wr + C_ONE;
            end
          end
        end
        ST_STREAM: begin
          if (bus.wr) begin
            r_err_ovf <= 1'b1;
          end
          if (r_k_ready && !bus.stall && r_fin2) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= ST_FILL;
      endcase

      if (r_issue && w_adv) begin
        if (!w_kx_end) begin
          r_kx <= r_kx + C_ONE;
        end else begin
          r_kx <= '0;
          if (!w_ky_end) begin
            r_ky      <= r_ky + C_ONE;
            r_ky_base <= r_ky_base + C_MW;
          end else begin
            r_ky      <= '0;
            r_ky_base <= '0;
            if (!w_ch_end) begin
              r_ch      <= r_ch + C_ONE;
              r_ch_base <= r_ch_base + C_PLANE;
            end else begin
              r_ch      <= '0;
              r_ch_base <= '0;
              if (!w_ox_end) begin
                r_ox      <= r_ox + C_ONE;
                r_ox_base <= r_ox_base + C_STR;
              end else begin
                r_ox      <= '0;
                r_ox_base <= '0;
                if (!w_oy_end) begin
                  r_oy      <= r_oy + C_ONE;
                  r_oy_base <= r_oy_base + C_ROWSTEP;
                end else begin
                  r_oy      <= '0;
                  r_oy_base <= '0;
                  if (!w_pass_end) begin
                    r_pass <= r_pass + PW'(1);
                  end else begin
                    r_pass  <= '0;
                    r_issue <= 1'b0;
                  end
                end
              end
            end
          end
        end
      end

      if (w_adv) begin
        r_v1      <= r_issue;
        r_last1   <= r_issue & w_win_end;
        r_loop1   <= r_issue & w_pass_done;
        r_fin1    <= r_issue & w_final;
        if (r_issue) begin
          r_rd_addr <= w_addr;
        end
        r_k_ready <= r_v1;
        r_k_last  <= r_v1 & r_last1;
        r_k_loop  <= r_v1 & r_loop1;
        r_fin2    <= r_v1 & r_fin1;
        if (r_v1) begin
          r_map_out <= r_mem[r_rd_addr];
        end
      end
    end
  end

  assign bus.map_out = r_map_out;
  assign bus.k_ready = r_k_ready;
  assign bus.k_last  = r_k_last;
  assign bus.k_loop  = r_k_loop;
  assign bus.ready   = r_ready;
  assign bus.err_ovf = r_err_ovf;

endmodule
